// File: rtl/forward_hazard_unit.sv
// Operand forwarding and hazard detection for the ID stage.
// Selects each read port's operand from the EX/MEM/WB/multi-cycle bypass network.
// Detects load-use and multi-cycle (mul/div) scoreboard hazards and raises a single stall.
// Keeps a 32-entry busy scoreboard plus saturating stall-cycle statistics.
module forward_hazard_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NPORT = 2,
    parameter int unsigned CNTW  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [5*NPORT-1:0]    ID_rs,
    input  logic [NPORT-1:0]      ID_re,
    input  logic [4:0]            ID_rd,
    input  logic                  ID_we,
    input  logic                  ID_md,
    input  logic [4:0]            EX_rd,
    input  logic [4:0]            MEM_rd,
    input  logic [4:0]            WB_rd,
    input  logic                  EX_we,
    input  logic                  MEM_we,
    input  logic                  WB_we,
    input  logic                  EX_load,
    input  logic                  md_done,
    input  logic [4:0]            md_rd,
    input  logic [XLEN*NPORT-1:0] init_read_data,
    input  logic [XLEN-1:0]       EX_alu_res,
    input  logic [XLEN-1:0]       MEM_wdata,
    input  logic [XLEN-1:0]       WB_wdata,
    input  logic [XLEN-1:0]       md_wdata,
    input  logic                  stat_clr,
    output logic [XLEN*NPORT-1:0] read_data,
    output logic                  stall,
    output logic [1:0]            stall_cause,
    output logic [31:0]           busy_vec,
    output logic [CNTW-1:0]       lu_stall_cnt,
    output logic [CNTW-1:0]       md_stall_cnt
);

    // Scoreboard and statistics state
    logic [31:0]      r_busy;
    logic [31:0]      w_busy_d;
    logic [31:0]      w_busy_eff;
    logic [CNTW-1:0]  r_lu_cnt;
    logic [CNTW-1:0]  r_md_cnt;
    logic [CNTW-1:0]  w_lu_cnt_d;
    logic [CNTW-1:0]  w_md_cnt_d;

    // Per-port decode
    logic [4:0]       w_rs      [NPORT];
    logic [XLEN-1:0]  w_fwd     [NPORT];
    logic [NPORT-1:0] w_cand;
    logic [NPORT-1:0] w_lu_hit;
    logic [NPORT-1:0] w_md_hit;

    // Hazard summary
    logic             w_waw;
    logic             w_lu_haz;
    logic             w_md_haz;
    logic             w_stall;
    logic             w_issue;

    // Stage match qualifiers shared by all ports
    logic             w_ex_src;
    logic             w_mem_src;
    logic             w_wb_src;
    logic             w_lu_src;

    // The scoreboard reads as empty while reset is held, so stall depends on inputs only.
    assign w_busy_eff = rstn ? r_busy : 32'd0;

    // A load in EX has no data yet, so it can never feed the bypass.
    assign w_ex_src  = EX_we && (EX_rd != 5'd0) && !EX_load;
    assign w_mem_src = MEM_we && (MEM_rd != 5'd0);
    assign w_wb_src  = WB_we && (WB_rd != 5'd0);
    assign w_lu_src  = EX_load && EX_we && (EX_rd != 5'd0);

    genvar g;
    for (g = 0; g < NPORT; g++) begin : g_port
        assign w_rs[g]   = ID_rs[5*g +: 5];
        // x0 and disabled ports never match anything.
        assign w_cand[g] = ID_re[g] && (w_rs[g] != 5'd0);

        // Operand select: nearest producer wins, register file is the fallback.
        always_comb begin
            w_fwd[g] = init_read_data[XLEN*g +: XLEN];
            if (w_cand[g]) begin
                if (w_ex_src && (EX_rd == w_rs[g])) begin
                    w_fwd[g] = EX_alu_res;
                end else if (w_mem_src && (MEM_rd == w_rs[g])) begin
                    w_fwd[g] = MEM_wdata;
                end else if (w_wb_src && (WB_rd == w_rs[g])) begin
                    w_fwd[g] = WB_wdata;
                end else if (md_done && (md_rd == w_rs[g])) begin
                    w_fwd[g] = md_wdata;
                end
            end
        end

        assign read_data[XLEN*g +: XLEN] = w_fwd[g];

        assign w_lu_hit[g] = w_cand[g] && w_lu_src && (EX_rd == w_rs[g]);

        // A busy source that completes this very cycle is bypassed, not stalled on.
        assign w_md_hit[g] = w_cand[g] && w_busy_eff[w_rs[g]] &&
                             !(md_done && (md_rd == w_rs[g]));
    end

    // Writing a register with a multi-cycle result still pending would reorder writebacks.
    assign w_waw    = ID_we && w_busy_eff[ID_rd];
    assign w_lu_haz = |w_lu_hit;
    assign w_md_haz = (|w_md_hit) || w_waw;
    assign w_stall  = w_lu_haz || w_md_haz;

    assign stall       = w_stall;
    assign stall_cause = {w_md_haz, w_lu_haz};
    assign busy_vec    = w_busy_eff;

    assign w_issue = ID_md && ID_we && (ID_rd != 5'd0) && !w_stall;

    // Scoreboard next state: completion clears first so a same-cycle issue wins.
    always_comb begin
        w_busy_d = r_busy;
        if (md_done) begin
            w_busy_d[md_rd] = 1'b0;
        end
        if (w_issue) begin
            w_busy_d[ID_rd] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    // Statistics next state: saturating increments, clear has priority.
    always_comb begin
        w_lu_cnt_d = r_lu_cnt;
        w_md_cnt_d = r_md_cnt;
        if (w_lu_haz && (r_lu_cnt != {CNTW{1'b1}})) begin
            w_lu_cnt_d = r_lu_cnt + 1'b1;
        end
        if (w_md_haz && (r_md_cnt != {CNTW{1'b1}})) begin
            w_md_cnt_d = r_md_cnt + 1'b1;
        end
        if (stat_clr) begin
            w_lu_cnt_d = '0;
            w_md_cnt_d = '0;
        end
    end

    // State registers; reset drops any outstanding multi-cycle ops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy   <= 32'd0;
            r_lu_cnt <= '0;
            r_md_cnt <= '0;
        end else begin
            r_busy   <= w_busy_d;
            r_lu_cnt <= w_lu_cnt_d;
            r_md_cnt <= w_md_cnt_d;
        end
    end

    assign lu_stall_cnt = r_lu_cnt;
    assign md_stall_cnt = r_md_cnt;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: a driver applies directed and random cycles and
// queues the reference model's expectation; a negedge monitor pops and compares.
module tb_forward_hazard_unit;

    localparam int XLEN  = 64;
    localparam int NPORT = 2;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    typedef struct {
        logic [9:0]   rs;
        logic [1:0]   re;
        logic [4:0]   id_rd;
        logic         id_we;
        logic         id_md;
        logic [4:0]   ex_rd;
        logic [4:0]   mem_rd;
        logic [4:0]   wb_rd;
        logic         ex_we;
        logic         mem_we;
        logic         wb_we;
        logic         ex_load;
        logic         md_done;
        logic [4:0]   md_rd;
        logic [127:0] init;
        logic [63:0]  ex;
        logic [63:0]  mem;
        logic [63:0]  wb;
        logic [63:0]  mdw;
        logic         stat_clr;
        logic         rstn;
    } stim_t;

    typedef struct {
        logic [127:0]    rd;
        logic            stall;
        logic [1:0]      cause;
        logic [31:0]     busy;
        logic [CNTW-1:0] lu;
        logic [CNTW-1:0] md;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b1;
    logic [5*NPORT-1:0]    ID_rs = '0;
    logic [NPORT-1:0]      ID_re = '0;
    logic [4:0]            ID_rd = '0;
    logic                  ID_we = 1'b0;
    logic                  ID_md = 1'b0;
    logic [4:0]            EX_rd = '0;
    logic [4:0]            MEM_rd = '0;
    logic [4:0]            WB_rd = '0;
    logic                  EX_we = 1'b0;
    logic                  MEM_we = 1'b0;
    logic                  WB_we = 1'b0;
    logic                  EX_load = 1'b0;
    logic                  md_done = 1'b0;
    logic [4:0]            md_rd = '0;
    logic [XLEN*NPORT-1:0] init_read_data = '0;
    logic [XLEN-1:0]       EX_alu_res = '0;
    logic [XLEN-1:0]       MEM_wdata = '0;
    logic [XLEN-1:0]       WB_wdata = '0;
    logic [XLEN-1:0]       md_wdata = '0;
    logic                  stat_clr = 1'b0;
    logic [XLEN*NPORT-1:0] read_data;
    logic                  stall;
    logic [1:0]            stall_cause;
    logic [31:0]           busy_vec;
    logic [CNTW-1:0]       lu_stall_cnt;
    logic [CNTW-1:0]       md_stall_cnt;

    forward_hazard_unit #(
        .XLEN (XLEN),
        .NPORT(NPORT),
        .CNTW (CNTW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ID_rs         (ID_rs),
        .ID_re         (ID_re),
        .ID_rd         (ID_rd),
        .ID_we         (ID_we),
        .ID_md         (ID_md),
        .EX_rd         (EX_rd),
        .MEM_rd        (MEM_rd),
        .WB_rd         (WB_rd),
        .EX_we         (EX_we),
        .MEM_we        (MEM_we),
        .WB_we         (WB_we),
        .EX_load       (EX_load),
        .md_done       (md_done),
        .md_rd         (md_rd),
        .init_read_data(init_read_data),
        .EX_alu_res    (EX_alu_res),
        .MEM_wdata     (MEM_wdata),
        .WB_wdata      (WB_wdata),
        .md_wdata      (md_wdata),
        .stat_clr      (stat_clr),
        .read_data     (read_data),
        .stall         (stall),
        .stall_cause   (stall_cause),
        .busy_vec      (busy_vec),
        .lu_stall_cnt  (lu_stall_cnt),
        .md_stall_cnt  (md_stall_cnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Reference state: which registers await a multi-cycle result, and the stall tallies.
    bit m_busy[32];
    int m_lu;
    int m_md;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a result every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("read_data", read_data, e.rd);
            chk("stall", {127'd0, stall}, {127'd0, e.stall});
            chk("stall_cause", {126'd0, stall_cause}, {126'd0, e.cause});
            chk("busy_vec", {96'd0, busy_vec}, {96'd0, e.busy});
            chk("lu_stall_cnt", {{(128-CNTW){1'b0}}, lu_stall_cnt}, {{(128-CNTW){1'b0}}, e.lu});
            chk("md_stall_cnt", {{(128-CNTW){1'b0}}, md_stall_cnt}, {{(128-CNTW){1'b0}}, e.md});
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rstn = 1'b1;
        return s;
    endfunction

    // One cycle: drive, queue what the model says must appear, then advance the model.
    task automatic step(input stim_t s);
        exp_t       e;
        logic [4:0] rs;
        logic [63:0] data;
        bit         cand;
        bit         lu;
        bit         mdh;
        bit         issue;
        @(posedge clk);
        #1;
        rstn           = s.rstn;
        ID_rs          = s.rs;
        ID_re          = s.re;
        ID_rd          = s.id_rd;
        ID_we          = s.id_we;
        ID_md          = s.id_md;
        EX_rd          = s.ex_rd;
        MEM_rd         = s.mem_rd;
        WB_rd          = s.wb_rd;
        EX_we          = s.ex_we;
        MEM_we         = s.mem_we;
        WB_we          = s.wb_we;
        EX_load        = s.ex_load;
        md_done        = s.md_done;
        md_rd          = s.md_rd;
        init_read_data = s.init;
        EX_alu_res     = s.ex;
        MEM_wdata      = s.mem;
        WB_wdata       = s.wb;
        md_wdata       = s.mdw;
        stat_clr       = s.stat_clr;

        if (!s.rstn) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_lu = 0;
            m_md = 0;
        end

        lu  = 1'b0;
        mdh = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            rs   = s.rs[5*p +: 5];
            cand = s.re[p] && (rs != 5'd0);
            data = s.init[64*p +: 64];
            if (cand) begin
                if (s.ex_we && s.ex_rd == rs && !s.ex_load) data = s.ex;
                else if (s.mem_we && s.mem_rd == rs) data = s.mem;
                else if (s.wb_we && s.wb_rd == rs) data = s.wb;
                else if (s.md_done && s.md_rd == rs) data = s.mdw;
                if (s.ex_load && s.ex_we && s.ex_rd == rs) lu = 1'b1;
                if (m_busy[rs] && !(s.md_done && s.md_rd == rs)) mdh = 1'b1;
            end
            e.rd[64*p +: 64] = data;
        end
        if (s.id_we && m_busy[s.id_rd]) mdh = 1'b1;

        e.stall = lu || mdh;
        e.cause = {mdh, lu};
        for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
        e.lu = CNTW'(m_lu);
        e.md = CNTW'(m_md);
        exp_q.push_back(e);

        if (s.rstn) begin
            if (lu && m_lu < CMAX) m_lu++;
            if (mdh && m_md < CMAX) m_md++;
            if (s.stat_clr) begin
                m_lu = 0;
                m_md = 0;
            end
            issue = s.id_md && s.id_we && (s.id_rd != 5'd0) && !(lu || mdh);
            if (s.md_done) m_busy[s.md_rd] = 1'b0;
            if (issue) m_busy[s.id_rd] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_lu = 0;
        m_md = 0;
        #2 rstn = 1'b0;

        // Held in reset
        s = idle();
        s.rstn = 1'b0;
        step(s);
        step(s);

        // Forward priority EX > MEM > WB on x5
        s = idle();
        s.rs = 10'd5; s.re = 2'b01;
        s.ex_rd = 5; s.mem_rd = 5; s.wb_rd = 5;
        s.ex_we = 1; s.mem_we = 1; s.wb_we = 1;
        s.ex = 64'h1; s.mem = 64'h2; s.wb = 64'h3;
        step(s);
        s.ex_we = 0;
        step(s);
        s.mem_we = 0;
        step(s);

        // x0 guard
        s = idle();
        s.ex_rd = 0; s.ex_we = 1; s.ex = 64'hDEAD;
        s.rs = 10'd0; s.re = 2'b11;
        s.init = {64'h0, 64'hAA};
        step(s);

        // Load-use on port 1, then released
        s = idle();
        s.ex_load = 1; s.ex_we = 1; s.ex_rd = 7; s.ex = 64'hBAD;
        s.rs = {5'd7, 5'd0}; s.re = 2'b10;
        s.init = {64'h77, 64'h0};
        step(s);
        s.ex_load = 0;
        step(s);

        // Multi-cycle scoreboard on x9
        s = idle();
        s.stat_clr = 1;
        step(s);
        s = idle();
        s.id_md = 1; s.id_we = 1; s.id_rd = 9;
        step(s);
        s = idle();
        s.rs = 10'd9; s.re = 2'b01;
        repeat (3) step(s);
        s.md_done = 1; s.md_rd = 9; s.mdw = 64'h55;
        step(s);
        s = idle();
        step(s);

        // Same-cycle issue and completion to x4, then reset mid-stall
        s = idle();
        s.id_md = 1; s.id_we = 1; s.id_rd = 4; s.md_done = 1; s.md_rd = 4;
        step(s);
        s = idle();
        s.rs = 10'd4; s.re = 2'b01;
        step(s);
        step(s);
        s.rstn = 0;
        step(s);
        s.rstn = 1;
        step(s);
        // Stale completion after reset is ignored
        s.md_done = 1; s.md_rd = 4;
        step(s);

        // Randomized traffic over a narrow register range to provoke collisions
        for (int n = 0; n < 500; n++) begin
            s = idle();
            s.rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            s.re       = 2'($urandom);
            s.id_rd    = 5'($urandom_range(0, 7));
            s.id_we    = 1'($urandom);
            s.id_md    = ($urandom_range(0, 2) == 0);
            s.ex_rd    = 5'($urandom_range(0, 7));
            s.mem_rd   = 5'($urandom_range(0, 7));
            s.wb_rd    = 5'($urandom_range(0, 7));
            s.ex_we    = 1'($urandom);
            s.mem_we   = 1'($urandom);
            s.wb_we    = 1'($urandom);
            s.ex_load  = ($urandom_range(0, 3) == 0);
            s.md_done  = ($urandom_range(0, 2) == 0);
            s.md_rd    = 5'($urandom_range(0, 7));
            s.init     = {$urandom, $urandom, $urandom, $urandom};
            s.ex       = {$urandom, $urandom};
            s.mem      = {$urandom, $urandom};
            s.wb       = {$urandom, $urandom};
            s.mdw      = {$urandom, $urandom};
            s.stat_clr = ($urandom_range(0, 39) == 0);
            s.rstn     = ($urandom_range(0, 99) != 0);
            step(s);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameters SHALL be: XLEN 64, register width; NPORT 2, ID read-port count (1..4); CNTW 32, stall-counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, rising-edge clock.
- rstn, in, 1, asynchronous active-low reset.
- ID_rs, in, 5*NPORT, source register index per port; port p at bits [5p+4:5p].
- ID_re, in, NPORT, per-port read-enable.
- ID_rd, in, 5, ID destination register.
- ID_we, in, 1, ID writes ID_rd.
- ID_md, in, 1, ID instruction is a multi-cycle (mul/div) op.
- EX_rd, MEM_rd, WB_rd, in, 5 each, stage destination registers.
- EX_we, MEM_we, WB_we, in, 1 each, stage write-enables.
- EX_load, in, 1, EX instruction is a load.
- md_done, in, 1, multi-cycle result valid this cycle.
- md_rd, in, 5, destination of the completing multi-cycle op.
- init_read_data, in, XLEN*NPORT, register-file read data per port.
- EX_alu_res, MEM_wdata, WB_wdata, md_wdata, in, XLEN each, bypass sources.
- stat_clr, in, 1, synchronous clear of the statistics counters.
- read_data, out, XLEN*NPORT, forwarded operands.
- stall, out, 1, hold IF/ID and insert a bubble into EX.
- stall_cause, out, 2, 0 none, 1 load-use, 2 md-busy, 3 both.
- busy_vec, out, 32, scoreboard contents.
- lu_stall_cnt, md_stall_cnt, out, CNTW each, stall-cycle counters.

Function
REQ-003 A port p SHALL be a match candidate only when ID_re[p]=1 and ID_rs[p]!=0.
REQ-004 read_data[p] SHALL be selected combinationally with priority EX, then MEM, then WB, then md_done, then init_read_data[p].
REQ-005 Each bypass stage SHALL match only when its we=1, its rd!=0 and its rd equals ID_rs[p]; the md bypass matches when md_done=1 and md_rd equals ID_rs[p].
REQ-006 EX SHALL NOT be a forwarding source when EX_load=1.
REQ-007 A port with ID_re[p]=0 SHALL output init_read_data[p].
REQ-008 The load-use condition SHALL be: EX_load=1, EX_we=1, EX_rd!=0, and EX_rd equals any candidate ID_rs[p].
REQ-009 The scoreboard SHALL be a 32-bit register busy[31:0]; busy[0] SHALL be constant 0.
REQ-010 The md hazard SHALL be: any candidate ID_rs[p] with busy set and not cleared by md_done this cycle, or ID_we=1 with busy[ID_rd]=1 (WAW).
REQ-011 stall SHALL equal load-use OR md hazard, combinationally; stall_cause SHALL encode which conditions hold.
REQ-012 An md issue SHALL occur at a clock edge when ID_md=1, ID_we=1, ID_rd!=0 and stall=0; it SHALL set busy[ID_rd] at that edge.
REQ-013 md_done=1 SHALL clear busy[md_rd] at the edge.
REQ-014 If an issue and md_done target the same register in the same cycle, busy SHALL end at 1 (set wins).
REQ-015 md_done for a register that is not busy SHALL be ignored without error.
REQ-016 Each cycle with a load-use stall SHALL increment lu_stall_cnt by 1; each cycle with an md-hazard stall SHALL increment md_stall_cnt by 1; both SHALL saturate at all-ones.
REQ-017 stat_clr=1 SHALL zero both counters at the edge, overriding any increment in that cycle.
REQ-018 The unit SHALL hold no other state and SHALL contain no latches.

Reset
REQ-019 rstn=0 SHALL asynchronously clear busy, lu_stall_cnt and md_stall_cnt to 0.
REQ-020 During reset, stall SHALL be driven by the current inputs only, with the scoreboard reading 0.
REQ-021 Reset applied mid-operation SHALL discard outstanding md ops; a later md_done SHALL be ignored per REQ-015.

Verification
REQ-022 Forward priority: EX/MEM/WB all write x5 with 0x1/0x2/0x3, ID_rs port0=5 -> read_data port0=0x1; drop EX_we -> 0x2; drop MEM_we -> 0x3.
REQ-023 x0 guard: EX_rd=0, EX_we=1, ID_rs=0, init_read_data=0xAA -> read_data=0xAA, stall=0.
REQ-024 Load-use: EX_load=1, EX_rd=7, ID_rs port1=7 -> stall=1, cause=1, EX not forwarded; next cycle with EX_load=0 -> stall=0; lu_stall_cnt=1.
REQ-025 md scoreboard: issue to x9, then ID reads x9 for 3 cycles -> stall=1, cause=2, md_stall_cnt=3; md_done, md_rd=9, md_wdata=0x55 -> same-cycle stall=0, read_data=0x55, busy_vec[9]=0 next cycle.
REQ-026 Same-cycle collision: issue to x4 with md_done md_rd=4 -> busy_vec[4]=1; rstn pulsed low mid-stall -> busy_vec=0 and counters=0 immediately.
